// File: rtl/mon_pkg.sv
// mon_pkg: types and helpers shared by the commit monitor, its watchdog and
// the testbench.
//   mon_state_t  - monitor FSM encoding (RUN / HALTED / ERROR)
//   commit_pkt_t - one retired instruction as seen at writeback
//   commit_check - returns 1 when a retire violates an architectural rule
package mon_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_ERROR  = 2'd2
  } mon_state_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_rdata;
    logic [31:0] rs2_rdata;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic [31:0] pc_rdata;
    logic [31:0] pc_wdata;
    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
  } commit_pkt_t;

  // A retire is illegal if it writes a nonzero value to x0, performs a read
  // and a write in the same instruction, or uses a misaligned pc.
  function automatic logic commit_check(input commit_pkt_t p);
    logic bad_x0;
    logic bad_mem;
    logic bad_pc;
    bad_x0  = (p.rd_addr == 5'd0) && (p.rd_wdata != 32'd0);
    bad_mem = (p.mem_rmask != 4'd0) && (p.mem_wmask != 4'd0);
    bad_pc  = (p.pc_rdata[1:0] != 2'b00) || (p.pc_wdata[1:0] != 2'b00);
    return bad_x0 || bad_mem || bad_pc;
  endfunction

endpackage

// File: rtl/mon_watchdog.sv
// mon_watchdog: counts consecutive enabled cycles without a kick.
//   clk, rst  - clock, synchronous active-high reset
//   kick      - clears the idle count (an instruction retired)
//   enable    - count only while set; the count holds otherwise
//   expired   - high in the cycle whose edge brings the count to TIMEOUT,
//               so the owner can register the error on that same edge
// TIMEOUT == 0 disables expiry entirely.
module mon_watchdog #(
  parameter logic [31:0] TIMEOUT = 32'd10000
) (
  input  logic clk,
  input  logic rst,
  input  logic kick,
  input  logic enable,
  output logic expired
);

  logic [31:0] count;
  logic [31:0] count_inc;

  assign count_inc = count + 32'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (kick) begin
      count <= '0;
    end else if (enable) begin
      count <= count_inc;
    end
  end

  // Compare against the incremented value: after TIMEOUT idle cycles the
  // owner's state has already moved, i.e. error is visible right after them.
  assign expired = (TIMEOUT != 32'd0) && enable && !kick && (count_inc == TIMEOUT);

endmodule

// File: rtl/mon_commit.sv
// mon_commit: retirement monitor. Registers every retired instruction onto a
// monitor channel with a running retirement index, detects a self-loop halt,
// architectural violations and a retire watchdog timeout.
//   clk, rst     - clock, synchronous active-high reset
//   in_valid     - one instruction retires this cycle
//   in_pkt       - retire fields of that instruction
//   mon_valid    - monitor channel valid (one cycle per accepted retire)
//   mon_order    - retirement index of the presented instruction
//   mon_pkt      - registered copy of the accepted in_pkt
//   halt, error  - sticky status, cleared only by rst
//   state        - debug view of the FSM (mon_state_t encoding)
//
// Channel semantics: valid-only, no ready. A retire is accepted whenever
// in_valid=1 while the FSM is in RUN; it appears on mon_* exactly one cycle
// later. mon_pkt and mon_order hold their last values while mon_valid=0.
module mon_commit
  import mon_pkg::*;
#(
  parameter logic [31:0] TIMEOUT = 32'd10000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  commit_pkt_t in_pkt,
  output logic        mon_valid,
  output logic [63:0] mon_order,
  output commit_pkt_t mon_pkt,
  output logic        halt,
  output logic        error,
  output logic [1:0]  state
);

  mon_state_t  state_q;
  mon_state_t  state_d;
  logic        accept;
  logic        check_fail;
  logic        self_loop;
  logic        wd_expired;
  logic [63:0] order_cnt;

  assign check_fail = commit_check(in_pkt);
  assign self_loop  = (in_pkt.pc_wdata == in_pkt.pc_rdata);

  mon_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .kick    (accept),
    .enable  (state_q == ST_RUN),
    .expired (wd_expired)
  );

  // Next state. A violation takes priority over a halt on the same retire.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      ST_RUN: begin
        accept = in_valid;
        if ((in_valid && check_fail) || wd_expired) begin
          state_d = ST_ERROR;
        end else if (in_valid && self_loop) begin
          state_d = ST_HALTED;
        end
      end
      ST_HALTED: state_d = ST_HALTED;
      ST_ERROR:  state_d = ST_ERROR;
      default:   state_d = ST_ERROR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RUN;
      mon_valid <= 1'b0;
      mon_order <= '0;
      mon_pkt   <= '0;
      order_cnt <= '0;
    end else begin
      state_q   <= state_d;
      mon_valid <= accept;
      if (accept) begin
        mon_pkt   <= in_pkt;
        mon_order <= order_cnt;
        order_cnt <= order_cnt + 64'd1;
      end
    end
  end

  // HALTED/ERROR are absorbing, so decoding them gives sticky flags that rise
  // in the same cycle the offending retire is presented on mon_valid.
  assign halt  = (state_q == ST_HALTED);
  assign error = (state_q == ST_ERROR);
  assign state = state_q;

endmodule

// File: tb/tb_mon_commit.sv
// tb_mon_commit: directed bench for mon_commit. A main instance (default
// TIMEOUT) covers streaming, halt, violations and reset; two more instances
// with TIMEOUT=5 and TIMEOUT=0 cover the watchdog.
module tb_mon_commit;
  import mon_pkg::*;

  localparam int PW = $bits(commit_pkt_t);
  localparam int EW = 64 + PW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid;
  commit_pkt_t in_pkt;
  logic        mon_valid;
  logic [63:0] mon_order;
  commit_pkt_t mon_pkt;
  logic        halt;
  logic        error;
  logic [1:0]  state;

  logic        wd_rst;
  logic        wd_valid;
  commit_pkt_t wd_pkt;
  logic        t5_valid, t0_valid;
  logic [63:0] t5_order, t0_order;
  commit_pkt_t t5_pkt, t0_pkt;
  logic        t5_halt, t0_halt, t5_error, t0_error;
  logic [1:0]  t5_state, t0_state;

  mon_commit dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_pkt(in_pkt),
    .mon_valid(mon_valid), .mon_order(mon_order), .mon_pkt(mon_pkt),
    .halt(halt), .error(error), .state(state)
  );

  mon_commit #(.TIMEOUT(32'd5)) dut_t5 (
    .clk(clk), .rst(wd_rst), .in_valid(wd_valid), .in_pkt(wd_pkt),
    .mon_valid(t5_valid), .mon_order(t5_order), .mon_pkt(t5_pkt),
    .halt(t5_halt), .error(t5_error), .state(t5_state)
  );

  mon_commit #(.TIMEOUT(32'd0)) dut_t0 (
    .clk(clk), .rst(wd_rst), .in_valid(wd_valid), .in_pkt(wd_pkt),
    .mon_valid(t0_valid), .mon_order(t0_order), .mon_pkt(t0_pkt),
    .halt(t0_halt), .error(t0_error), .state(t0_state)
  );

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int            checks   = 0;
  int            failures = 0;
  logic [63:0]   m_order;
  commit_pkt_t   last_pkt;

  task automatic check_bit(input string tag, input logic obs, input logic want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, want);
    end
  endtask

  task automatic check_vec(input string tag, input logic [63:0] obs, input logic [63:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic check_pkt(input string tag, input commit_pkt_t obs, input commit_pkt_t want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  // One clock; then compare the main channel against the scoreboard.
  task automatic tick();
    logic [EW-1:0] e;
    @(posedge clk);
    #1;
    check_bit("mon_valid", mon_valid, exp_q.size() > 0);
    if (mon_valid && (exp_q.size() > 0)) begin
      e = exp_q.pop_front();
      check_vec("mon_order", mon_order, e[EW-1:PW]);
      check_pkt("mon_pkt", mon_pkt, e[PW-1:0]);
    end
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  function automatic commit_pkt_t good_pkt(input logic [31:0] pc);
    commit_pkt_t p;
    p.inst      = $urandom;
    p.rs1_addr  = 5'($urandom_range(0, 31));
    p.rs2_addr  = 5'($urandom_range(0, 31));
    p.rs1_rdata = $urandom;
    p.rs2_rdata = $urandom;
    p.rd_addr   = 5'($urandom_range(1, 31));
    p.rd_wdata  = $urandom;
    p.pc_rdata  = pc;
    p.pc_wdata  = pc + 32'd4;
    p.mem_addr  = $urandom;
    p.mem_rmask = 4'($urandom_range(0, 15));
    p.mem_wmask = 4'd0;
    p.mem_rdata = $urandom;
    p.mem_wdata = $urandom;
    return p;
  endfunction

  task automatic retire(input commit_pkt_t p, input logic accepted);
    in_valid = 1'b1;
    in_pkt   = p;
    if (accepted) begin
      exp_q.push_back({m_order, p});
      m_order  = m_order + 64'd1;
      last_pkt = p;
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check_vec({tag, "_order"}, mon_order, 64'd0);
    check_pkt({tag, "_pkt"}, mon_pkt, '0);
    check_bit({tag, "_halt"}, halt, 1'b0);
    check_bit({tag, "_error"}, error, 1'b0);
    check_vec({tag, "_state"}, 64'(state), 64'(ST_RUN));
  endtask

  // Reset with a retire presented in the same cycle; it must be dropped.
  task automatic do_reset();
    rst = 1'b1;
    retire(good_pkt(32'h1000), 1'b0);
    rst      = 1'b0;
    m_order  = '0;
    last_pkt = '0;
    check_reset_values("reset");
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    commit_pkt_t p;
    rst = 1'b1; in_valid = 1'b0; in_pkt = '0;
    wd_rst = 1'b1; wd_valid = 1'b0; wd_pkt = '0;
    m_order = '0; last_pkt = '0;

    do_reset();

    // Back-to-back stream pc 0x0, 0x4, 0x8.
    for (int i = 0; i < 3; i++) retire(good_pkt(32'(i * 4)), 1'b1);
    check_bit("stream_halt", halt, 1'b0);
    check_bit("stream_error", error, 1'b0);
    tick();
    check_pkt("pkt_hold", mon_pkt, last_pkt);

    // Continue to order 7, then reset with a retire in the reset cycle.
    for (int i = 3; i < 8; i++) retire(good_pkt(32'(i * 4)), 1'b1);
    check_vec("order_before_rst", mon_order, 64'd7);
    do_reset();
    retire(good_pkt(32'h200), 1'b1);
    check_vec("order_after_rst", mon_order, 64'd0);

    // Self-loop halt at 0x40 as order 2.
    retire(good_pkt(32'h204), 1'b1);
    p = good_pkt(32'h40);
    p.pc_wdata = 32'h40;
    retire(p, 1'b1);
    check_bit("halt_set", halt, 1'b1);
    check_bit("halt_no_error", error, 1'b0);
    check_vec("halt_state", 64'(state), 64'(ST_HALTED));
    for (int i = 0; i < 3; i++) retire(good_pkt(32'h300 + 32'(i * 4)), 1'b0);
    check_vec("halted_order", mon_order, 64'd2);
    check_pkt("halted_pkt", mon_pkt, p);
    check_bit("halt_sticky", halt, 1'b1);

    // Nonzero write to x0.
    do_reset();
    retire(good_pkt(32'h400), 1'b1);
    p = good_pkt(32'h404);
    p.rd_addr = 5'd0;
    p.rd_wdata = 32'h1;
    retire(p, 1'b1);
    check_bit("x0_error", error, 1'b1);
    check_bit("x0_halt", halt, 1'b0);
    check_vec("x0_state", 64'(state), 64'(ST_ERROR));
    for (int i = 0; i < 2; i++) retire(good_pkt(32'h500), 1'b0);
    check_vec("error_order", mon_order, 64'd1);

    // Zero written to x0 is legal.
    do_reset();
    p = good_pkt(32'h600);
    p.rd_addr = 5'd0;
    p.rd_wdata = 32'h0;
    retire(p, 1'b1);
    check_bit("x0_zero_ok", error, 1'b0);

    // Remaining violation kinds: read+write, misaligned pc_rdata / pc_wdata.
    for (int k = 0; k < 3; k++) begin
      do_reset();
      p = good_pkt(32'h700);
      case (k)
        0: begin p.mem_rmask = 4'h1; p.mem_wmask = 4'h2; end
        1: p.pc_rdata = 32'h701;
        default: p.pc_wdata = 32'h706;
      endcase
      retire(p, 1'b1);
      check_bit($sformatf("viol%0d_error", k), error, 1'b1);
      check_bit($sformatf("viol%0d_halt", k), halt, 1'b0);
    end

    // Halt and misalign on the same retire: error wins.
    do_reset();
    p = good_pkt(32'h42);
    p.pc_wdata = 32'h42;
    retire(p, 1'b1);
    check_bit("both_error", error, 1'b1);
    check_bit("both_halt", halt, 1'b0);
    repeat (3) tick();
    check_bit("error_sticky", error, 1'b1);

    // Watchdog: one retire, then idle.
    wd_rst = 1'b1;
    tick();
    check_bit("t5_reset_error", t5_error, 1'b0);
    wd_rst = 1'b0;
    wd_valid = 1'b1;
    wd_pkt = good_pkt(32'h0);
    tick();
    wd_valid = 1'b0;
    check_bit("t5_retire_valid", t5_valid, 1'b1);
    for (int i = 1; i <= 7; i++) begin
      tick();
      check_bit($sformatf("t5_error_idle%0d", i), t5_error, i >= 5);
    end
    repeat (93) tick();
    check_bit("t0_error", t0_error, 1'b0);
    check_bit("t0_halt", t0_halt, 1'b0);
    check_vec("t0_state", 64'(t0_state), 64'(ST_RUN));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
